// File: rtl/mem_responder_if.sv
// Request/response bus between a control unit and mem_responder.
// Master drives the request; slave returns registered status and data.
interface mem_responder_if;
  logic        req;
  logic        MEMWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req, MEMWrite, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, MEMWrite, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency single-port word memory with a busy/ready handshake.
// The array is touched only on the edge that enters DONE.
module mem_responder #(
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
  localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);
  localparam bit          LAT1     = (LATENCY == 1);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        busy_q;
  logic        err_q;

  logic [31:0] mem_q [0:WORDS-1];

  logic                  accept;
  logic                  done_d;
  logic                  a_we;
  logic [31:0]           a_addr;
  logic [31:0]           a_wdata;
  logic                  a_bad;
  logic [DEPTH_LOG2-1:0] a_idx;
  logic                  mem_we;

  assign accept = bus.req &&
                  (state_q == IDLE || state_q == DONE);

  // With a one-cycle latency the access completes on the
  // accepting edge, so it must use the live request fields.
  assign done_d  = LAT1 ? accept
                        : (state_q == WAIT && cnt_q == 3'd1);
  assign a_we    = LAT1 ? bus.MEMWrite : we_q;
  assign a_addr  = LAT1 ? bus.addr     : addr_q;
  assign a_wdata = LAT1 ? bus.wdata    : wdata_q;

  assign a_bad  = (a_addr[1:0] != 2'b00) ||
                  ((a_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign a_idx  = a_addr[DEPTH_LOG2+1:2];
  assign mem_we = reset && done_d && a_we && !a_bad;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[a_idx] <= a_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      if (accept) begin
        we_q    <= bus.MEMWrite;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      case (state_q)
        IDLE, DONE: begin
          if (!bus.req) begin
            state_q <= IDLE;
          end else if (LAT1) begin
            state_q <= DONE;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd1) begin
            state_q <= DONE;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q  <= cnt_q - 3'd1;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 3'd0;
        end
      endcase
      if (done_d) begin
        ready_q <= 1'b1;
        err_q   <= a_bad;
        if (!a_we) begin
          rdata_q <= a_bad ? 32'd0 : mem_q[a_idx];
        end
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_mem_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  mem_responder_if i3();
  mem_responder_if i1();

  mem_responder #(.LATENCY(3), .DEPTH_LOG2(8)) u3 (
    .clk(clk), .reset(rst_n), .bus(i3.slave)
  );
  mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) u1 (
    .clk(clk), .reset(rst_n), .bus(i1.slave)
  );

  // model: one pending transaction per DUT, completing
  // LATENCY-1 edges after the accepting edge
  int          lat_of [2] = '{3, 1};
  logic [31:0] m_mem   [2][256];
  bit          m_known [2][256];
  bit          m_pend  [2];
  longint      m_done_at [2];
  bit          m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wd    [2];
  bit          x_ready [2];
  bit          x_busy  [2];
  bit          x_err   [2];
  bit          x_rk    [2];
  logic [31:0] x_rd    [2];
  longint      edge_n = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endfunction

  function automatic void step(int d, logic rq, logic w,
                               logic [31:0] a, logic [31:0] wd);
    bit bad;
    int unsigned wi;
    if (!m_pend[d] && rq === 1'b1) begin
      m_pend[d]    = 1'b1;
      m_done_at[d] = edge_n + lat_of[d] - 1;
      m_we[d]      = w;
      m_addr[d]    = a;
      m_wd[d]      = wd;
    end
    x_ready[d] = 1'b0;
    x_err[d]   = 1'b0;
    if (m_pend[d] && m_done_at[d] == edge_n) begin
      m_pend[d]  = 1'b0;
      x_ready[d] = 1'b1;
      bad = (m_addr[d] % 4 != 0) || (m_addr[d] >= 32'd1024);
      x_err[d] = bad;
      wi = m_addr[d] / 4;
      if (m_we[d]) begin
        if (!bad) begin
          m_mem[d][wi[7:0]]   = m_wd[d];
          m_known[d][wi[7:0]] = 1'b1;
        end
      end else if (bad) begin
        x_rd[d] = 32'd0;
        x_rk[d] = 1'b1;
      end else begin
        x_rd[d] = m_mem[d][wi[7:0]];
        x_rk[d] = m_known[d][wi[7:0]];
      end
    end
    x_busy[d] = m_pend[d];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_pend[d]  = 1'b0;
        x_ready[d] = 1'b0;
        x_busy[d]  = 1'b0;
        x_err[d]   = 1'b0;
        x_rd[d]    = 32'd0;
        x_rk[d]    = 1'b1;
      end
    end else begin
      edge_n++;
      step(0, i3.req, i3.MEMWrite, i3.addr, i3.wdata);
      step(1, i1.req, i1.MEMWrite, i1.addr, i1.wdata);
    end
  end

  function automatic void cmp(int d, logic r, logic b, logic e,
                              logic [31:0] rd);
    chk($sformatf("ready%0d", d), 32'(r), 32'(x_ready[d]));
    chk($sformatf("busy%0d", d),  32'(b), 32'(x_busy[d]));
    chk($sformatf("err%0d", d),   32'(e), 32'(x_err[d]));
    if (x_rk[d]) chk($sformatf("rdata%0d", d), rd, x_rd[d]);
  endfunction

  always @(negedge clk) begin
    cmp(0, i3.ready, i3.busy, i3.err, i3.rdata);
    cmp(1, i1.ready, i1.busy, i1.err, i1.rdata);
  end

  task automatic drive(int d, logic r, logic w, logic [31:0] a,
                       logic [31:0] wd);
    if (d == 0) begin
      i3.req = r; i3.MEMWrite = w; i3.addr = a; i3.wdata = wd;
    end else begin
      i1.req = r; i1.MEMWrite = w; i1.addr = a; i1.wdata = wd;
    end
  endtask

  function automatic logic rdy_of(int d);
    return (d == 0) ? i3.ready : i1.ready;
  endfunction

  // Issue one request at the current negedge and wait for its ready.
  task automatic xact(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic e, output int lat, output int nb);
    drive(d, 1'b1, w, a, wd);
    lat = 0; nb = 0; rd = 32'd0; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
      if ((d == 0) ? i3.busy : i1.busy) nb++;
      if (rdy_of(d)) begin
        lat = k;
        rd  = (d == 0) ? i3.rdata : i1.rdata;
        e   = (d == 0) ? i3.err : i1.err;
        break;
      end
    end
    if (lat == 0) begin
      checks++; fails++;
      $display("FAIL xact_timeout: no ready for addr %h", a);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom % 16;
    logic [31:0] w = 32'(($urandom % 32) * 4);
    if (r == 0) return $urandom | 32'h400;
    if (r == 1) return w | 32'(1 + $urandom % 3);
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, r1, r2;
    logic e;
    int lat, nb, first, second, pulses;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    @(negedge clk);
    chk("rst_ready", 32'(i3.ready), 32'd0);
    chk("rst_busy",  32'(i3.busy),  32'd0);
    chk("rst_err",   32'(i3.err),   32'd0);
    chk("rst_rdata", i3.rdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    xact(0, 1'b1, 32'h0, $urandom, rd, e, lat, nb);
    chk("first_lat", 32'(lat), 32'd3);
    for (int i = 1; i < 256; i++)
      xact(0, 1'b1, 32'(i * 4), $urandom, rd, e, lat, nb);
    for (int i = 0; i < 256; i++)
      xact(1, 1'b1, 32'(i * 4), $urandom, rd, e, lat, nb);

    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat, nb);
    chk("wr10_err", 32'(e), 32'd0);
    xact(0, 1'b0, 32'h10, 32'd0, rd, e, lat, nb);
    chk("rd10_lat",  32'(lat), 32'd3);
    chk("rd10_busy", 32'(nb),  32'd2);
    chk("rd10_data", rd,       32'hDEADBEEF);
    chk("rd10_err",  32'(e),   32'd0);

    xact(0, 1'b1, 32'h0, 32'h11, rd, e, lat, nb);
    xact(0, 1'b1, 32'h4, 32'h22, rd, e, lat, nb);
    drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
    first = 0; second = 0; r1 = 32'd0; r2 = 32'd0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) i3.addr = 32'h4;
      if (i3.ready) begin
        if (first == 0) begin
          first = k; r1 = i3.rdata;
        end else begin
          second = k; r2 = i3.rdata;
          drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
          break;
        end
      end
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("b2b_gap",  32'(second - first), 32'd3);
    chk("b2b_rd1",  r1, 32'h11);
    chk("b2b_rd2",  r2, 32'h22);

    xact(0, 1'b1, 32'h30, 32'h3030, rd, e, lat, nb);
    drive(0, 1'b1, 1'b0, 32'h40, 32'd0);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("pulse_busy", 32'(i3.busy), 32'd1);
        drive(0, 1'b1, 1'b1, 32'h30, 32'h00000BAD);
      end
      if (k == 2) drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      if (i3.ready) pulses++;
    end
    chk("pulse_count", 32'(pulses), 32'd1);
    xact(0, 1'b0, 32'h30, 32'd0, rd, e, lat, nb);
    chk("pulse_keep", rd, 32'h3030);

    xact(0, 1'b1, 32'h13, 32'hFFFF, rd, e, lat, nb);
    chk("mis_err", 32'(e), 32'd1);
    xact(0, 1'b0, 32'h400, 32'd0, rd, e, lat, nb);
    chk("oor_err",  32'(e), 32'd1);
    chk("oor_data", rd,     32'd0);
    @(negedge clk);
    chk("oor_hold", i3.rdata, 32'd0);
    xact(0, 1'b0, 32'h10, 32'd0, rd, e, lat, nb);
    chk("mis_keep", rd, 32'hDEADBEEF);

    xact(0, 1'b1, 32'h20, 32'hCAFE0020, rd, e, lat, nb);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("abort_busy", 32'(i3.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy",  32'(i3.busy),  32'd0);
    chk("async_ready", 32'(i3.ready), 32'd0);
    chk("async_err",   32'(i3.err),   32'd0);
    chk("async_rdata", i3.rdata,      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 1'b0, 32'h20, 32'd0, rd, e, lat, nb);
    chk("abort_keep", rd, 32'hCAFE0020);

    xact(1, 1'b1, 32'h10, 32'h5A5A0010, rd, e, lat, nb);
    xact(1, 1'b0, 32'h10, 32'd0, rd, e, lat, nb);
    chk("l1_lat",  32'(lat), 32'd1);
    chk("l1_busy", 32'(nb),  32'd0);
    chk("l1_data", rd,       32'h5A5A0010);

    for (int c = 0; c < 400; c++) begin
      drive(0, ($urandom % 3) != 0, 1'($urandom % 2), rand_addr(),
            $urandom);
      drive(1, ($urandom % 3) != 0, 1'($urandom % 2), rand_addr(),
            $urandom);
      if (c == 200) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
